// File: rtl/safe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : safe_pkg
// Brief    : Shared state encoding, key codes and sizing for the safe lock.
// Revision : 1.0
// ============================================================================
package safe_pkg;

   typedef enum logic [2:0] {
      ST_OFF      = 3'd0,
      ST_LOCKED   = 3'd1,
      ST_UNLOCKED = 3'd2,
      ST_SETPW    = 3'd3,
      ST_LOCKOUT  = 3'd4
   } state_t;

   localparam logic [3:0] KEY_STAR  = 4'hA;
   localparam logic [3:0] KEY_SHARP = 4'hB;
   localparam logic [3:0] KEY_NONE  = 4'hF;

   localparam int PW_DIGITS         = 6;
   localparam int LOCKOUT_LIMIT_DEF = 3;

   function automatic logic is_digit(input logic [3:0] code);
      return (code <= 4'd9);
   endfunction

endpackage
`default_nettype wire

// File: rtl/safe_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : safe_controller_if
// Brief    : Keypad, mode-request and status signals of the safe controller.
// Revision : 1.0
// ============================================================================
interface safe_controller_if;
   logic       row1, row2, row3, row4;
   logic       col1, col2, col3;
   logic       reset_password;
   logic       initialize;
   logic [5:0] password_led;
   logic [2:0] state;

   modport master (
      output row1, row2, row3, row4, col1, col2, col3, reset_password, initialize,
      input  password_led, state
   );

   modport slave (
      input  row1, row2, row3, row4, col1, col2, col3, reset_password, initialize,
      output password_led, state
   );
endinterface
`default_nettype wire

// File: rtl/keypad_decoder.sv
`default_nettype none
// ============================================================================
// Module   : keypad_decoder
// Brief    : Synchronizes keypad/mode inputs, decodes one key, emits press edge.
// Revision : 1.0
// ============================================================================
module keypad_decoder
   import safe_pkg::*;
(
   input  wire logic       clk,
   input  wire logic       rst_n,
   input  wire logic [3:0] rows,
   input  wire logic [2:0] cols,
   input  wire logic       reset_password,
   input  wire logic       initialize,
   output logic [3:0]      code,
   output logic            key_event,
   output logic            reset_password_s,
   output logic            initialize_s
);

   logic [8:0] r_meta;
   logic [8:0] r_sync;
   logic [3:0] r_prev_code;
   logic [3:0] w_code;
   logic [3:0] w_rows;
   logic [2:0] w_cols;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta      <= '0;
         r_sync      <= '0;
         r_prev_code <= KEY_NONE;
      end else begin
         r_meta      <= {initialize, reset_password, cols, rows};
         r_sync      <= r_meta;
         r_prev_code <= w_code;
      end
   end

   assign w_rows = r_sync[3:0];
   assign w_cols = r_sync[6:4];

   // Only exact single-row/single-column patterns match; anything else is NONE.
   always_comb begin
      w_code = KEY_NONE;
      case ({w_rows, w_cols})
         7'b0001_001: w_code = 4'd1;
         7'b0001_010: w_code = 4'd2;
         7'b0001_100: w_code = 4'd3;
         7'b0010_001: w_code = 4'd4;
         7'b0010_010: w_code = 4'd5;
         7'b0010_100: w_code = 4'd6;
         7'b0100_001: w_code = 4'd7;
         7'b0100_010: w_code = 4'd8;
         7'b0100_100: w_code = 4'd9;
         7'b1000_001: w_code = KEY_STAR;
         7'b1000_010: w_code = 4'd0;
         7'b1000_100: w_code = KEY_SHARP;
         default:     w_code = KEY_NONE;
      endcase
   end

   assign code             = w_code;
   assign key_event        = (w_code != KEY_NONE) && (r_prev_code == KEY_NONE);
   assign reset_password_s = r_sync[7];
   assign initialize_s     = r_sync[8];

endmodule
`default_nettype wire

// File: rtl/safe_controller.sv
`default_nettype none
// ============================================================================
// Module   : safe_controller
// Brief    : Keypad-driven 6-digit safe lock FSM; SAFE_LOCKOUT_EN adds lockout.
// Revision : 1.0
// ============================================================================
module safe_controller
   import safe_pkg::*;
#(
   parameter logic [23:0] DEFAULT_PW    = 24'h000000,
   parameter int          LOCKOUT_LIMIT = LOCKOUT_LIMIT_DEF
)(
   input  wire logic        clk,
   input  wire logic        rst_n,
   safe_controller_if.slave bus
);

   logic [3:0]  w_code;
   logic        w_event;
   logic        w_rstpw;
   logic        w_init;
   logic        w_star;
   logic        w_sharp;
   logic        w_digit;

   state_t      r_state, w_state_nxt;
   logic [23:0] r_buf, w_buf_nxt;
   logic [23:0] r_pw, w_pw_nxt;
   logic [2:0]  r_cnt, w_cnt_nxt;
   logic [5:0]  w_led;

   keypad_decoder u_decoder (
      .clk              (clk),
      .rst_n            (rst_n),
      .rows             ({bus.row4, bus.row3, bus.row2, bus.row1}),
      .cols             ({bus.col3, bus.col2, bus.col1}),
      .reset_password   (bus.reset_password),
      .initialize       (bus.initialize),
      .code             (w_code),
      .key_event        (w_event),
      .reset_password_s (w_rstpw),
      .initialize_s     (w_init)
   );

   assign w_star  = w_event && (w_code == KEY_STAR);
   assign w_sharp = w_event && (w_code == KEY_SHARP);
   assign w_digit = w_event && is_digit(w_code) && (r_cnt < 3'(PW_DIGITS));

`ifdef SAFE_LOCKOUT_EN
   localparam int FAIL_W = $clog2(LOCKOUT_LIMIT + 1);
   logic [FAIL_W-1:0] r_fail, w_fail_nxt;
`else
   // LOCKOUT_LIMIT has no effect without the lockout build.
   if (LOCKOUT_LIMIT < 1) begin : g_limit_unused
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_OFF;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_buf  <= '0;
         r_pw   <= DEFAULT_PW;
         r_cnt  <= '0;
`ifdef SAFE_LOCKOUT_EN
         r_fail <= '0;
`endif
      end else begin
         r_buf  <= w_buf_nxt;
         r_pw   <= w_pw_nxt;
         r_cnt  <= w_cnt_nxt;
`ifdef SAFE_LOCKOUT_EN
         r_fail <= w_fail_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_buf_nxt   = r_buf;
      w_cnt_nxt   = r_cnt;
      w_pw_nxt    = r_pw;
`ifdef SAFE_LOCKOUT_EN
      w_fail_nxt  = r_fail;
`endif
      if (w_init) begin
         w_pw_nxt  = DEFAULT_PW;
         w_buf_nxt = '0;
         w_cnt_nxt = '0;
`ifdef SAFE_LOCKOUT_EN
         w_fail_nxt = '0;
`endif
         case (r_state)
            ST_LOCKED, ST_UNLOCKED, ST_SETPW, ST_LOCKOUT: w_state_nxt = ST_LOCKED;
            default:                                      w_state_nxt = ST_OFF;
         endcase
      end else begin
         case (r_state)
            ST_OFF: begin
               if (w_sharp) begin
                  w_state_nxt = ST_LOCKED;
                  w_buf_nxt   = '0;
                  w_cnt_nxt   = '0;
               end
            end
            ST_LOCKED: begin
               if (w_sharp) begin
                  w_state_nxt = ST_OFF;
                  w_buf_nxt   = '0;
                  w_cnt_nxt   = '0;
               end else if (w_star) begin
                  w_buf_nxt = '0;
                  w_cnt_nxt = '0;
                  if ((r_cnt == 3'(PW_DIGITS)) && (r_buf == r_pw)) begin
                     w_state_nxt = ST_UNLOCKED;
`ifdef SAFE_LOCKOUT_EN
                     w_fail_nxt  = '0;
                  end else begin
                     w_fail_nxt = r_fail + 1'b1;
                     if (r_fail >= FAIL_W'(LOCKOUT_LIMIT - 1)) w_state_nxt = ST_LOCKOUT;
`endif
                  end
               end else if (w_digit) begin
                  w_buf_nxt = {r_buf[19:0], w_code};
                  w_cnt_nxt = r_cnt + 3'd1;
               end
            end
            ST_UNLOCKED: begin
               if (w_sharp) begin
                  w_state_nxt = ST_OFF;
                  w_buf_nxt   = '0;
                  w_cnt_nxt   = '0;
               end else if (w_rstpw) begin
                  w_state_nxt = ST_SETPW;
                  w_buf_nxt   = '0;
                  w_cnt_nxt   = '0;
               end else if (w_star) begin
                  w_state_nxt = ST_LOCKED;
                  w_buf_nxt   = '0;
                  w_cnt_nxt   = '0;
               end
            end
            ST_SETPW: begin
               if (w_sharp) begin
                  w_state_nxt = ST_OFF;
                  w_buf_nxt   = '0;
                  w_cnt_nxt   = '0;
               end else if (w_star) begin
                  if (r_cnt == 3'(PW_DIGITS)) begin
                     w_pw_nxt    = r_buf;
                     w_state_nxt = ST_UNLOCKED;
                  end
                  w_buf_nxt = '0;
                  w_cnt_nxt = '0;
               end else if (w_digit) begin
                  w_buf_nxt = {r_buf[19:0], w_code};
                  w_cnt_nxt = r_cnt + 3'd1;
               end
            end
`ifdef SAFE_LOCKOUT_EN
            ST_LOCKOUT: ;
`endif
            default: begin
               w_state_nxt = ST_OFF;
               w_buf_nxt   = '0;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   always_comb begin
      w_led = '0;
      if ((r_state == ST_LOCKED) || (r_state == ST_SETPW)) begin
         for (int i = 0; i < PW_DIGITS; i++) w_led[i] = (r_cnt > 3'(i));
      end
   end

   assign bus.password_led = w_led;
   assign bus.state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_safe_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_safe_controller
// Brief    : Directed self-checking bench; SAFE_LOCKOUT_EN enables lockout vectors.
// Revision : 1.0
// ============================================================================
module tb_safe_controller;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   safe_controller_if bus ();

   safe_controller #(
      .DEFAULT_PW    (24'h000000),
      .LOCKOUT_LIMIT (3)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_lines(input logic [3:0] rows, input logic [2:0] cols);
      bus.row1 = rows[0];
      bus.row2 = rows[1];
      bus.row3 = rows[2];
      bus.row4 = rows[3];
      bus.col1 = cols[0];
      bus.col2 = cols[1];
      bus.col3 = cols[2];
   endtask

   task automatic key_lines(input logic [3:0] k);
      int idx;
      if (k == 4'h0)      set_lines(4'b1000, 3'b010);
      else if (k == 4'hA) set_lines(4'b1000, 3'b001);
      else if (k == 4'hB) set_lines(4'b1000, 3'b100);
      else begin
         idx = int'(k) - 1;
         set_lines(4'b0001 << (idx / 3), 3'b001 << (idx % 3));
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic [3:0] k, input int hold = 4);
      @(negedge clk);
      key_lines(k);
      cycles(hold);
      set_lines(4'b0000, 3'b000);
      cycles(4);
   endtask

   task automatic enter_pw(input logic [23:0] pw);
      for (int i = 5; i >= 0; i--) press(pw[i*4 +: 4]);
   endtask

   task automatic pulse_rstpw();
      @(negedge clk);
      bus.reset_password = 1'b1;
      cycles(4);
      bus.reset_password = 1'b0;
      cycles(3);
   endtask

   task automatic pulse_init();
      @(negedge clk);
      bus.initialize = 1'b1;
      cycles(4);
      bus.initialize = 1'b0;
      cycles(3);
   endtask

   logic [5:0] therm [6] = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3F};

   initial begin
      set_lines(4'b0000, 3'b000);
      bus.reset_password = 1'b0;
      bus.initialize     = 1'b0;
      cycles(3);
      check_eq("rst_state", 32'(bus.state), 32'd0);
      check_eq("rst_led", 32'(bus.password_led), 32'h00);
      rst_n = 1'b1;
      cycles(4);
      check_eq("post_rst_state", 32'(bus.state), 32'd0);

      // Open with the default password, watching the thermometer fill up.
      press(4'hB);
      check_eq("off_to_locked", 32'(bus.state), 32'd1);
      for (int i = 0; i < 6; i++) begin
         press(4'h0);
         check_eq("led_thermo", 32'(bus.password_led), 32'(therm[i]));
      end
      press(4'hA);
      check_eq("unlock_state", 32'(bus.state), 32'd2);
      check_eq("unlock_led", 32'(bus.password_led), 32'h00);

      // Change the password to 123456.
      @(negedge clk);
      bus.reset_password = 1'b1;
      cycles(4);
      check_eq("setpw_state", 32'(bus.state), 32'd3);
      bus.reset_password = 1'b0;
      cycles(3);
      enter_pw(24'h123456);
      check_eq("setpw_led", 32'(bus.password_led), 32'h3F);
      press(4'hA);
      check_eq("setpw_store", 32'(bus.state), 32'd2);
      press(4'hA);
      check_eq("relock", 32'(bus.state), 32'd1);
      press(4'hB);
      check_eq("sharp_off", 32'(bus.state), 32'd0);
      press(4'hB);
      check_eq("sharp_on", 32'(bus.state), 32'd1);
      enter_pw(24'h123456);
      press(4'hA);
      check_eq("new_pw_unlock", 32'(bus.state), 32'd2);

      // Short wrong entry, then a held key.
      press(4'hA);
      press(4'h1);
      press(4'h2);
      press(4'h3);
      check_eq("three_digits_led", 32'(bus.password_led), 32'h07);
      press(4'hA);
      check_eq("wrong_state", 32'(bus.state), 32'd1);
      check_eq("wrong_led", 32'(bus.password_led), 32'h00);
      press(4'h1, 20);
      check_eq("held_key_once", 32'(bus.password_led), 32'h01);

      // Two columns high is not a key.
      @(negedge clk);
      set_lines(4'b0001, 3'b011);
      cycles(6);
      set_lines(4'b0000, 3'b000);
      cycles(4);
      check_eq("multi_col_none", 32'(bus.password_led), 32'h01);

      // Slide from key 2 straight to key 3: only the 2 registers.
      @(negedge clk);
      key_lines(4'h2);
      cycles(4);
      key_lines(4'h3);
      cycles(4);
      set_lines(4'b0000, 3'b000);
      cycles(4);
      check_eq("key_to_key", 32'(bus.password_led), 32'h03);
      press(4'h3);
      press(4'h4);
      press(4'h5);
      press(4'h6);
      check_eq("six_led", 32'(bus.password_led), 32'h3F);
      press(4'h9);
      check_eq("seventh_led", 32'(bus.password_led), 32'h3F);
      press(4'hA);
      check_eq("seventh_ignored", 32'(bus.state), 32'd2);

      // Initialize from UNLOCKED restores the default password.
      @(negedge clk);
      bus.initialize = 1'b1;
      cycles(4);
      check_eq("init_state", 32'(bus.state), 32'd1);
      check_eq("init_led", 32'(bus.password_led), 32'h00);
      bus.initialize = 1'b0;
      cycles(3);
      enter_pw(24'h000000);
      press(4'hA);
      check_eq("init_default_pw", 32'(bus.state), 32'd2);
      press(4'hB);
      pulse_init();
      check_eq("init_in_off", 32'(bus.state), 32'd0);

      press(4'hB);
`ifdef SAFE_LOCKOUT_EN
      press(4'hA);
      press(4'hA);
      check_eq("two_wrong", 32'(bus.state), 32'd1);
      press(4'hA);
      check_eq("lockout_state", 32'(bus.state), 32'd4);
      press(4'hB);
      check_eq("lockout_sharp", 32'(bus.state), 32'd4);
      press(4'h1);
      check_eq("lockout_led", 32'(bus.password_led), 32'h00);
      pulse_init();
      check_eq("lockout_init", 32'(bus.state), 32'd1);
      enter_pw(24'h000000);
      press(4'hA);
      check_eq("lockout_default_pw", 32'(bus.state), 32'd2);
`else
      press(4'hA);
      press(4'hA);
      press(4'hA);
      check_eq("no_lockout", 32'(bus.state), 32'd1);
      enter_pw(24'h000000);
      press(4'hA);
      check_eq("no_lockout_unlock", 32'(bus.state), 32'd2);
`endif
      press(4'hB);
      check_eq("back_off", 32'(bus.state), 32'd0);

      // Async reset mid password-set loses the changed password.
      press(4'hB);
      enter_pw(24'h000000);
      press(4'hA);
      pulse_rstpw();
      enter_pw(24'h654321);
      press(4'hA);
      check_eq("pw_654321", 32'(bus.state), 32'd2);
      pulse_rstpw();
      press(4'h1);
      press(4'h2);
      press(4'h3);
      press(4'h4);
      check_eq("setpw_four", 32'(bus.password_led), 32'h0F);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("async_rst_state", 32'(bus.state), 32'd0);
      check_eq("async_rst_led", 32'(bus.password_led), 32'h00);
      @(negedge clk);
      rst_n = 1'b1;
      cycles(4);
      check_eq("release_no_event", 32'(bus.state), 32'd0);
      press(4'hB);
      enter_pw(24'h000000);
      press(4'hA);
      check_eq("rst_default_pw", 32'(bus.state), 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/safe_controller.md
SAFE_CONTROLLER -- requirements
Module: safe_controller

Interface
REQ-001 Parameter DEFAULT_PW, 24'h000000: power-up/initialize password, six BCD digits, most significant nibble first.
REQ-002 Parameter LOCKOUT_LIMIT, 3: consecutive wrong submits that cause lockout (used only with SAFE_LOCKOUT_EN).
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 row1..row4  input  1 each  keypad row lines, active-high, asynchronous to clk.
REQ-007 col1..col3  input  1 each  keypad column lines, active-high, asynchronous to clk.
REQ-008 reset_password  input  1  level request to enter password-set mode.
REQ-009 initialize  input  1  level request to restore DEFAULT_PW.
REQ-010 password_led  output  6  thermometer count of digits entered.
REQ-011 state  output  3  current FSM state code.

Function
REQ-012 All row, col, reset_password and initialize inputs SHALL pass through a 2-flop synchronizer before use.
REQ-013 Decode SHALL map row1 = 1,2,3; row2 = 4,5,6; row3 = 7,8,9; row4 = *,0,# (col1..col3) to codes 0-9, * = 4'hA, # = 4'hB.
REQ-014 Zero keys, or more than one row or column high, SHALL decode to NONE (4'hF).
REQ-015 A key event SHALL fire once, on the cycle the synchronized code changes from NONE to a valid code; a held key SHALL NOT repeat, and a direct key-to-key change SHALL NOT fire.
REQ-016 A key's effect SHALL appear on outputs after the 3rd rising clk edge following a stable raw press.
REQ-017 State codes: OFF = 0, LOCKED = 1, UNLOCKED = 2, SETPW = 3, LOCKOUT = 4; codes 5-7 are unreachable and SHALL recover to OFF.
REQ-018 OFF: only # acts, going to LOCKED with the entry buffer cleared; password_led = 0.
REQ-019 LOCKED/SETPW: a digit shifts into the 6-digit buffer and increments count; digits after the 6th are ignored.
REQ-020 LOCKED, *: if count = 6 and buffer equals the stored password, go to UNLOCKED and clear the fail counter; otherwise stay LOCKED and increment the fail counter; the buffer is cleared in both cases.
REQ-021 UNLOCKED: a synchronized reset_password high goes to SETPW with the buffer cleared; * goes to LOCKED.
REQ-022 SETPW, *: if count = 6, store the buffer as the password and go to UNLOCKED; otherwise clear the buffer and stay in SETPW.
REQ-023 # in any state other than OFF SHALL go to OFF and clear the buffer; the stored password is kept.
REQ-024 A synchronized initialize high SHALL load DEFAULT_PW and clear the buffer and fail counter; LOCKOUT, UNLOCKED and SETPW go to LOCKED, and OFF stays OFF.
REQ-025 Priority when events coincide: initialize > # > reset_password > other keys.
REQ-026 password_led[i] SHALL be 1 iff count > i in LOCKED/SETPW, and 0 in all other states.

Reset
REQ-027 rst_n low SHALL immediately set: state OFF, password DEFAULT_PW, buffer 0, count 0, fail counter 0, synchronizers 0, previous code NONE, password_led 0.
REQ-028 Reset release SHALL NOT generate a key event.

Configuration
REQ-029 With macro SAFE_LOCKOUT_EN defined, LOCKOUT_LIMIT consecutive wrong submits SHALL go to LOCKOUT; LOCKOUT ignores all keys and exits only via initialize or rst_n.
REQ-030 Without SAFE_LOCKOUT_EN, the fail counter and LOCKOUT state SHALL be absent and wrong submits only stay in LOCKED.

Structure
REQ-031 Package safe_pkg SHALL hold the state enum, key codes (KEY_STAR = A, KEY_SHARP = B, KEY_NONE = F), PW_DIGITS = 6 and the LOCKOUT_LIMIT default.
REQ-032 Synchronizer and decode SHALL live in sub-module keypad_decoder, which outputs a 4-bit code and a 1-cycle key_event; the FSM, compare and storage stay in safe_controller.

Verification
REQ-033 Reset, #, then digits 0,0,0,0,0,0, then * -> password_led goes 000001..111111, then state = 2, password_led = 0.
REQ-034 In UNLOCKED, raise reset_password, then press 1,2,3,4,5,6 and * -> state 3 then 2; press *, #, #, then 1-6 and * -> state = 2.
REQ-035 In LOCKED, press 1,2,3 then * -> state stays 1, password_led = 0; hold a digit for 20 cycles -> count increments by exactly 1.
REQ-036 col1 and col2 high together with row1 -> no event and no password_led change; 7 digits entered -> password_led = 111111 and the 7th digit is ignored.
REQ-037 With SAFE_LOCKOUT_EN, 3 wrong submits -> state = 4 and keys are ignored; pulse initialize -> state = 1 and the password is DEFAULT_PW.
REQ-038 Assert rst_n low in SETPW with 4 digits entered -> state = 0 and password_led = 0 immediately, and the old password is lost (DEFAULT_PW restored).
